fifo_wr_arbiter: RTL

- Round-robin, packet-atomic arbiter sharing the asynchronous FIFO write port (store/data_in/fifo_full) among NUM_REQ write-domain requesters.
- Sits entirely in the w_clk domain, directly in front of the FIFO write side.
- Holds a grant until the owner's last beat. An idle-owner watchdog reclaims the port from stalled requesters.

---
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-atomic arbiter in front of an async FIFO write port.
// Grants are held until the owner's last beat or until the idle watchdog fires.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 8,
  parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          w_clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          store,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  input  logic                          timeout_clr,
  output logic                          timeout_err,
  output logic [ID_W-1:0]               err_id
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    StIdle,
    StGrant
  } state_e;

  state_e                state;
  logic [ID_W-1:0]       last_grant;
  logic [CntW-1:0]       idle_cnt;
  logic [ID_W-1:0]       pick;
  logic [ID_W-1:0]       idx;
  logic                  pick_valid;
  logic                  grant_st;
  logic                  owner_valid;
  logic                  owner_last;
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    pick       = '0;
    idx        = '0;
    pick_valid = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((32'(last_grant) + k) % NUM_REQ);
      if (!pick_valid && req_valid[idx]) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
    end
  end

  assign grant_st    = (state == StGrant);
  assign owner_valid = req_valid[grant_id];
  assign owner_last  = req_last[grant_id];
  assign store       = grant_st & owner_valid & ~fifo_full;
  assign busy        = grant_st;
  assign timeout_hit = grant_st & ~owner_valid & ~fifo_full &
                       (idle_cnt == CntW'(TIMEOUT - 1));

  always_comb begin
    req_ready = '0;
    data_in   = '0;
    if (grant_st) begin
      req_ready[grant_id] = ~fifo_full;
      data_in             = data_arr[grant_id];
    end
  end

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      last_grant  <= ID_W'(NUM_REQ - 1);
      grant_id    <= '0;
      err_id      <= '0;
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (pick_valid) begin
            grant_id <= pick;
            idle_cnt <= '0;
            state    <= StGrant;
          end
        end
        StGrant: begin
          if (store && owner_last) begin
            state      <= StIdle;
            last_grant <= grant_id;
          end else if (owner_valid) begin
            idle_cnt <= '0;
          end else if (!fifo_full) begin
            // A full FIFO freezes the watchdog; only genuine owner silence counts.
            if (timeout_hit) begin
              state      <= StIdle;
              last_grant <= grant_id;
              err_id     <= grant_id;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (timeout_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule
